// File: rtl/pipeline_id_hazard.sv
// Purpose : RISC-V decode stage: register file, write-first WB bypass, load-use hazard detection,
//           and the ID/EX pipeline register with bubble/flush insertion and perf counters.
// Latency : 1 cycle ID -> EX (registered); stall_if is combinational. Backpressure: stall_if holds IF/ID for one cycle on load-use.
//
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   inst_id, pc_id, valid_id, ctrl_id, imm_id, rs1_used, rs2_used, mem_read_id
//                       instruction currently in ID plus its decode results
//   wb_we, wb_addr, wb_data   register-file write port from WB
//   flush               kill the instruction in ID (taken branch/jump resolved in EX)
//   stall_if            hold PC and IF/ID
//   ex_*                ID/EX register contents
//   stall_cnt, bubble_cnt     saturating performance counters
module pipeline_id_hazard #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_id,
    input  logic [XLEN-1:0]   pc_id,
    input  logic              valid_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [XLEN-1:0]   imm_id,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              mem_read_id,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1_addr,
    output logic [4:0]        ex_rs2_addr,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              ex_mem_read,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int AW       = $clog2(NREG);
    localparam bit REDUCED  = (NREG == 16);

    logic [4:0] rs1, rs2, rd;
    assign rs1 = inst_id[19:15];
    assign rs2 = inst_id[24:20];
    assign rd  = inst_id[11:7];

    // Opcode/funct bits are decoded by the controller, not here.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{inst_id[31:25], inst_id[14:12], inst_id[6:0]};

    // x0 is hardwired to zero; addresses beyond NREG do not exist.
    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREG);
    endfunction

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_data, rs2_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && addr_ok(wb_addr)) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    // Write-first: a same-cycle WB write to the read address wins over the array.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (addr_ok(rs1)) rs1_data = (wb_we && wb_addr == rs1) ? wb_data : regs[rs1[AW-1:0]];
        if (addr_ok(rs2)) rs2_data = (wb_we && wb_addr == rs2) ? wb_data : regs[rs2[AW-1:0]];
    end

    logic hazard, illegal;
    assign hazard  = valid_id & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                     ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));
    // rd[4] only matters when the instruction actually does something (non-zero bundle).
    assign illegal = valid_id & REDUCED &
                     ((rs1_used & rs1[4]) | (rs2_used & rs2[4]) | (rd[4] & (|ctrl_id)));
    // A flush kills the dependent instruction anyway, so no stall is needed.
    assign stall_if = hazard & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
            ex_illegal  <= 1'b0;
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
        end else begin
            // Bubble by default; overwritten only when a real instruction advances.
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
            ex_mem_read <= 1'b0;
            ex_illegal  <= 1'b0;

            if (flush || hazard) begin
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
            if (!flush && hazard) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            end

            if (!flush && !hazard && valid_id) begin
                ex_valid    <= 1'b1;
                ex_pc       <= pc_id;
                ex_imm      <= imm_id;
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_rs1_addr <= rs1;
                ex_rs2_addr <= rs2;
                ex_rd       <= rd;
                // Illegal register use: neutralise the bundle, let downstream trap.
                if (illegal) begin
                    ex_ctrl     <= '0;
                    ex_mem_read <= 1'b0;
                    ex_illegal  <= 1'b1;
                end else begin
                    ex_ctrl     <= ctrl_id;
                    ex_mem_read <= mem_read_id;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_id_hazard.sv
module tb_pipeline_id_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_id, pc_id, imm_id, wb_data;
    logic        valid_id, rs1_used, rs2_used, mem_read_id, wb_we, flush;
    logic [15:0] ctrl_id;
    logic [4:0]  wb_addr;

    always #5 clk = ~clk;

    // DUT A: RV32I, 16-bit counters
    logic        a_stall_if, a_ex_valid, a_ex_mem_read, a_ex_illegal;
    logic [31:0] a_ex_pc, a_ex_imm, a_ex_rs1_data, a_ex_rs2_data;
    logic [4:0]  a_ex_rs1_addr, a_ex_rs2_addr, a_ex_rd;
    logic [15:0] a_ex_ctrl, a_stall_cnt, a_bubble_cnt;
    // DUT B: RV32E, 2-bit counters
    logic        b_stall_if, b_ex_valid, b_ex_mem_read, b_ex_illegal;
    logic [31:0] b_ex_pc, b_ex_imm, b_ex_rs1_data, b_ex_rs2_data;
    logic [4:0]  b_ex_rs1_addr, b_ex_rs2_addr, b_ex_rd;
    logic [15:0] b_ex_ctrl;
    logic [1:0]  b_stall_cnt, b_bubble_cnt;

    pipeline_id_hazard #(.XLEN(32), .NREG(32), .CTRL_W(16), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id),
        .ctrl_id(ctrl_id), .imm_id(imm_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .mem_read_id(mem_read_id), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall_if(a_stall_if), .ex_valid(a_ex_valid), .ex_pc(a_ex_pc),
        .ex_imm(a_ex_imm), .ex_rs1_data(a_ex_rs1_data), .ex_rs2_data(a_ex_rs2_data),
        .ex_rs1_addr(a_ex_rs1_addr), .ex_rs2_addr(a_ex_rs2_addr), .ex_rd(a_ex_rd),
        .ex_ctrl(a_ex_ctrl), .ex_mem_read(a_ex_mem_read), .ex_illegal(a_ex_illegal),
        .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt));

    pipeline_id_hazard #(.XLEN(32), .NREG(16), .CTRL_W(16), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id),
        .ctrl_id(ctrl_id), .imm_id(imm_id), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .mem_read_id(mem_read_id), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .stall_if(b_stall_if), .ex_valid(b_ex_valid), .ex_pc(b_ex_pc),
        .ex_imm(b_ex_imm), .ex_rs1_data(b_ex_rs1_data), .ex_rs2_data(b_ex_rs2_data),
        .ex_rs1_addr(b_ex_rs1_addr), .ex_rs2_addr(b_ex_rs2_addr), .ex_rd(b_ex_rd),
        .ex_ctrl(b_ex_ctrl), .ex_mem_read(b_ex_mem_read), .ex_illegal(b_ex_illegal),
        .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt));

    // Packed view of the ID/EX register: valid,pc,imm,rs1d,rs2d,rs1a,rs2a,rd,ctrl,mem_read,illegal
    typedef logic [161:0] vec_t;
    vec_t a_vec, b_vec;
    assign a_vec = {a_ex_valid, a_ex_pc, a_ex_imm, a_ex_rs1_data, a_ex_rs2_data, a_ex_rs1_addr,
                    a_ex_rs2_addr, a_ex_rd, a_ex_ctrl, a_ex_mem_read, a_ex_illegal};
    assign b_vec = {b_ex_valid, b_ex_pc, b_ex_imm, b_ex_rs1_data, b_ex_rs2_data, b_ex_rs1_addr,
                    b_ex_rs2_addr, b_ex_rd, b_ex_ctrl, b_ex_mem_read, b_ex_illegal};

    typedef struct {
        string tag;
        bit    on_b;
        vec_t  exp;
    } sb_t;
    sb_t sb[$];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t ev(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                                input logic [15:0] ctrl, input logic mr, input logic ill);
        return {v, pc, imm, r1, r2, a1, a2, rd, ctrl, mr, ill};
    endfunction

    task automatic push(input string tag, input bit on_b, input vec_t exp);
        sb_t s;
        s.tag = tag; s.on_b = on_b; s.exp = exp;
        sb.push_back(s);
    endtask

    // Advance one clock and retire every expectation queued for that edge.
    task automatic cyc();
        sb_t s;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            s = sb.pop_front();
            chk(s.tag, s.on_b ? b_vec : a_vec, s.exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] r1,
                          input logic [4:0] r2, input logic r1u, input logic r2u,
                          input logic mr, input logic [15:0] ctrl, input logic [31:0] pc,
                          input logic [31:0] imm);
        valid_id = v; inst_id = {7'b0, r2, r1, 3'b0, rd, 7'h33};
        rs1_used = r1u; rs2_used = r2u; mem_read_id = mr;
        ctrl_id = ctrl; pc_id = pc; imm_id = imm;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
        wb_we = we; wb_addr = addr; wb_data = data;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
        set_wb(0, 0, 32'h0);
        #1;
        chk("reset_ex", a_vec, '0);
        chk("reset_stall_if", vec_t'(a_stall_if), '0);
        chk("reset_cnt", vec_t'({a_stall_cnt, a_bubble_cnt}), '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write x5, nothing in ID.
        set_wb(1, 5'd5, 32'h1234);
        push("idle_bubble", 0, '0);
        cyc();
        // Read x5 back through the pipeline.
        set_wb(0, 0, 32'h0);
        set_id(1, 6, 5, 0, 1, 1, 0, 16'h1, 32'h100, 32'h0);
        push("read_x5", 0, ev(1, 32'h100, 0, 32'h1234, 0, 5, 0, 6, 16'h1, 0, 0));
        cyc();
        // Same-cycle bypass of x3.
        set_wb(1, 5'd3, 32'hDEADBEEF);
        set_id(1, 4, 3, 5, 1, 1, 0, 16'h2, 32'h104, 32'h0);
        push("bypass_x3", 0, ev(1, 32'h104, 0, 32'hDEADBEEF, 32'h1234, 3, 5, 4, 16'h2, 0, 0));
        cyc();
        // Write to x0 must be ignored, bypass included.
        set_wb(1, 5'd0, 32'hFFFF);
        set_id(1, 1, 0, 3, 1, 1, 0, 16'h3, 32'h108, 32'h0);
        push("x0_write", 0, ev(1, 32'h108, 0, 0, 32'hDEADBEEF, 0, 3, 1, 16'h3, 0, 0));
        cyc();
        // lw x7, 8(x5)
        set_wb(0, 0, 32'h0);
        set_id(1, 7, 5, 0, 1, 0, 1, 16'h4, 32'h10C, 32'h8);
        push("lw_x7", 0, ev(1, 32'h10C, 8, 32'h1234, 0, 5, 0, 7, 16'h4, 1, 0));
        cyc();
        // add x8,x7,x1 -> load-use; WB writes x7 in the same cycle.
        set_wb(1, 5'd7, 32'h77);
        set_id(1, 8, 7, 1, 1, 1, 0, 16'h5, 32'h110, 32'h0);
        #1;
        chk("loaduse_stall_if", vec_t'(a_stall_if), vec_t'(1'b1));
        push("loaduse_bubble", 0, '0);
        cyc();
        chk("loaduse_cnt", vec_t'({a_stall_cnt, a_bubble_cnt}), vec_t'({16'd1, 16'd1}));
        // Re-issue: stall gone, x7 holds the WB value.
        set_wb(0, 0, 32'h0);
        #1;
        chk("reissue_stall_if", vec_t'(a_stall_if), '0);
        push("reissue_add", 0, ev(1, 32'h110, 0, 32'h77, 0, 7, 1, 8, 16'h5, 0, 0));
        cyc();
        // lw x7 then addi x8,x9,4 with rs2 field = 7 but unused -> no stall.
        set_id(1, 7, 5, 0, 1, 0, 1, 16'h4, 32'h114, 32'h8);
        push("lw_x7_b", 0, ev(1, 32'h114, 8, 32'h1234, 0, 5, 0, 7, 16'h4, 1, 0));
        cyc();
        set_id(1, 8, 9, 7, 1, 0, 0, 16'h6, 32'h118, 32'h4);
        #1;
        chk("rs2_unused_stall_if", vec_t'(a_stall_if), '0);
        push("rs2_unused_addi", 0, ev(1, 32'h118, 4, 0, 32'h77, 9, 7, 8, 16'h6, 0, 0));
        cyc();
        chk("rs2_unused_cnt", vec_t'(a_stall_cnt), vec_t'(16'd1));
        // lw x7, then dependent add together with flush.
        set_id(1, 7, 5, 0, 1, 0, 1, 16'h4, 32'h11C, 32'h8);
        push("lw_x7_c", 0, ev(1, 32'h11C, 8, 32'h1234, 0, 5, 0, 7, 16'h4, 1, 0));
        cyc();
        set_id(1, 8, 7, 1, 1, 1, 0, 16'h5, 32'h120, 32'h0);
        flush = 1'b1;
        #1;
        chk("flush_hazard_stall_if", vec_t'(a_stall_if), '0);
        push("flush_bubble", 0, '0);
        cyc();
        chk("flush_cnt", vec_t'({a_stall_cnt, a_bubble_cnt}), vec_t'({16'd1, 16'd2}));
        // Invalid ID: bubble, counters untouched.
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
        push("invalid_bubble", 0, '0);
        cyc();
        chk("invalid_cnt", vec_t'({a_stall_cnt, a_bubble_cnt}), vec_t'({16'd1, 16'd2}));

        // Reset asserted mid-stall.
        set_id(1, 7, 5, 0, 1, 0, 1, 16'h4, 32'h124, 32'h8);
        push("lw_before_rst", 0, ev(1, 32'h124, 8, 32'h1234, 0, 5, 0, 7, 16'h4, 1, 0));
        cyc();
        set_id(1, 8, 7, 1, 1, 1, 0, 16'h5, 32'h128, 32'h0);
        #1;
        chk("pre_rst_stall_if", vec_t'(a_stall_if), vec_t'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ex", a_vec, '0);
        chk("async_rst_stall_if", vec_t'(a_stall_if), '0);
        chk("async_rst_cnt", vec_t'({a_stall_cnt, a_bubble_cnt}), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_id(1, 6, 5, 0, 1, 1, 0, 16'h1, 32'h130, 32'h0);
        push("x5_after_rst", 0, ev(1, 32'h130, 0, 0, 0, 5, 0, 6, 16'h1, 0, 0));
        cyc();

        // Five load-use stalls: A counts to 5, B saturates at 3.
        for (int i = 0; i < 5; i++) begin
            set_id(1, 7, 5, 0, 1, 0, 1, 16'h4, 32'h200, 32'h8);
            cyc();
            set_id(1, 8, 7, 1, 1, 1, 0, 16'h5, 32'h204, 32'h0);
            #1;
            chk("sat_loop_stall_if", vec_t'(a_stall_if & b_stall_if), vec_t'(1'b1));
            cyc();
        end
        chk("cnt_a_5", vec_t'({a_stall_cnt, a_bubble_cnt}), vec_t'({16'd5, 16'd5}));
        chk("cnt_b_sat", vec_t'({b_stall_cnt, b_bubble_cnt}), vec_t'({2'd3, 2'd3}));

        // RV32E: load reading x17 is illegal -> ctrl and mem_read cleared.
        set_id(1, 1, 17, 2, 1, 1, 1, 16'h9, 32'h300, 32'h0);
        push("e_illegal_rs1", 1, ev(1, 32'h300, 0, 0, 0, 17, 2, 1, 16'h0, 0, 1));
        push("i_legal_rs1", 0, ev(1, 32'h300, 0, 0, 0, 17, 2, 1, 16'h9, 1, 0));
        cyc();
        // Write to x20: ignored by RV32E, stored (and bypassed) by RV32I.
        set_wb(1, 5'd20, 32'h5555);
        set_id(1, 1, 2, 20, 1, 0, 0, 16'h7, 32'h304, 32'h0);
        push("e_x20_bypass", 1, ev(1, 32'h304, 0, 0, 0, 2, 20, 1, 16'h7, 0, 0));
        push("i_x20_bypass", 0, ev(1, 32'h304, 0, 0, 32'h5555, 2, 20, 1, 16'h7, 0, 0));
        cyc();
        set_wb(0, 0, 32'h0);
        set_id(1, 1, 2, 20, 1, 0, 0, 16'h7, 32'h308, 32'h0);
        push("e_x20_read", 1, ev(1, 32'h308, 0, 0, 0, 2, 20, 1, 16'h7, 0, 0));
        push("i_x20_read", 0, ev(1, 32'h308, 0, 0, 32'h5555, 2, 20, 1, 16'h7, 0, 0));
        cyc();
        // RV32E: rd=x16 with non-zero bundle is illegal.
        set_id(1, 16, 1, 2, 1, 1, 0, 16'h3, 32'h30C, 32'h0);
        push("e_illegal_rd", 1, ev(1, 32'h30C, 0, 0, 0, 1, 2, 16, 16'h0, 0, 1));
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_id_hazard.md
Name: pipeline_id_hazard

Overview:
Parametrised successor of the RISC-V pipeline decode stage. Holds the architectural register file (XLEN-wide, 16 or 32 entries), a write-first WB bypass, load-use hazard detection, and the ID/EX pipeline register with bubble/flush insertion and stall/bubble performance counters. Sits between the IF/ID register plus controller and the EX stage; the controller's decoded bundle is passed in as an opaque vector.

Parameters:
XLEN, 32, data/PC width (32 or 64)
NREG, 32, architectural registers (32 = RV32I, 16 = RV32E)
CTRL_W, 16, width of controller bundle carried to EX
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
inst_id  in  32  instruction in ID (rs1=[19:15], rs2=[24:20], rd=[11:7])
pc_id  in  XLEN  PC of instruction in ID
valid_id  in  1  ID holds a real instruction
ctrl_id  in  CTRL_W  decoded control bundle from controller
imm_id  in  XLEN  immediate from ImmGen
rs1_used  in  1  instruction reads rs1
rs2_used  in  1  instruction reads rs2
mem_read_id  in  1  instruction is a load
wb_we  in  1  WB register write enable
wb_addr  in  5  WB destination
wb_data  in  XLEN  WB data
flush  in  1  taken branch/jump resolved in EX; kill ID
stall_if  out  1  hold PC and IF/ID register (combinational)
ex_valid  out  1  ID/EX holds real instruction
ex_pc, ex_imm  out  XLEN  registered PC, immediate
ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
ex_rs1_addr, ex_rs2_addr, ex_rd  out  5  registered addresses
ex_ctrl  out  CTRL_W  registered bundle (zero on bubble)
ex_mem_read  out  1  registered load flag
ex_illegal  out  1  registered illegal-register flag
stall_cnt, bubble_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (async, rst=1): all registers x0..x(NREG-1)=0; all ex_* outputs 0; counters 0. Reset mid-stall drops the stall: stall_if follows ex_* = 0, so stall_if=0 while rst held.
- Register write: on posedge when wb_we=1, wb_addr!=0, wb_addr<NREG. Writes to x0 or addr>=NREG ignored.
- Read: combinational; address 0 or >=NREG reads 0. Write-first bypass: if wb_we && wb_addr==rsX && rsX!=0 && rsX<NREG, read returns wb_data same cycle.
- hazard = valid_id & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
- illegal = valid_id & (NREG==16) & ((rs1_used&rs1[4]) | (rs2_used&rs2[4]) | (rd[4] & ctrl_id!=0)).
- stall_if = hazard & ~flush.
- ID/EX update each posedge, priority order:
  1. flush=1: bubble (ex_valid=0, ex_ctrl=0, ex_mem_read=0, ex_illegal=0, other fields don't-care but driven 0); bubble_cnt+1.
  2. hazard=1: bubble as above; stall_cnt+1 and bubble_cnt+1. IF/ID held externally, so hazard clears next cycle (ex_valid=0). Load-use costs exactly 1 cycle.
  3. valid_id=0: bubble, no counter change.
  4. otherwise load: ex_valid=1, all fields from ID; ex_mem_read=mem_read_id; if illegal then ex_ctrl=0, ex_illegal=1 (trap logic downstream), ex_mem_read=0.
- Counters saturate at 2^CNT_W-1, never wrap.
- Simultaneous WB write and hazard: register still written; bypass value is captured when the stalled instruction re-issues.

Test Plan:
- Reset: write x5=0x1234, assert rst mid-cycle -> x5 reads 0, all ex_* 0, counters 0 immediately (async).
- Bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF, ID reads rs1=3 same cycle -> ex_rs1_data=0xDEADBEEF next edge; write to x0 -> x0 stays 0.
- Load-use: ex=lw x7 (ex_mem_read=1, ex_rd=7), ID add x8,x7,x1 -> stall_if=1 one cycle, one bubble, stall_cnt=1, then add enters EX with ex_valid=1.
- Rs2 unused: ID addi x8,x9,4 with inst[24:20]=7, rs2_used=0 after lw x7 -> no stall.
- Flush+hazard same cycle -> stall_if=0, bubble, bubble_cnt+1, stall_cnt unchanged.
- NREG=16: add x17 read (rs1=17) -> ex_illegal=1, ex_ctrl=0; write wb_addr=20 ignored; counters with CNT_W=2 saturate at 3 after 5 stalls.
